// File: rtl/kronos_if_fetch.sv
// kronos_if_fetch: instruction fetch stage, producer side of the IF/ID handshake.
// Owns the PC, masters the instruction bus and presents fetched {pc, ir} pairs
// from a 2-entry FIFO. A downstream redirect (flush) clears the FIFO and restarts
// fetch at the new target; an in-flight bus request is drained and its ack dropped.
// The fetch output packs {pc[31:0], ir[31:0]} with pc in bits [63:32].
// Optional build macro: KRONOS_IF_BUSERR_EN adds instr_err / fetch_err; an errored
// ack pushes a NOP flagged with err and halts fetch until the next flush or reset.
module kronos_if_fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
`ifdef KRONOS_IF_BUSERR_EN
    input  logic        instr_err,
    output logic        fetch_err,
`endif
    output logic [63:0] fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy,
    input  logic        flush,
    input  logic [31:0] flush_target
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    localparam logic [1:0]  FULL    = 2'(BUF_DEPTH);
    localparam logic [31:0] NOP_IR  = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  cnt_q, cnt_d;
    entry_t      buf0_q, buf0_d;
    entry_t      buf1_q, buf1_d;
    logic        halt_q, halt_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;

    logic        push;
    logic        pop;
    logic [1:0]  cnt_after;
    entry_t      new_entry;
    logic        new_err;
    logic        ack_is_err;

    // Low target bits are forced to zero; keep them visible to lint as intentionally unused.
    logic unused_tgt;
    assign unused_tgt = ^flush_target[1:0];

`ifdef KRONOS_IF_BUSERR_EN
    assign ack_is_err = instr_err;
    assign fetch_err  = err0_q;
`else
    assign ack_is_err = 1'b0;
`endif

    assign instr_req  = (state_q != IDLE);
    assign instr_addr = addr_q;
    assign fetch_vld  = (cnt_q != 2'd0);
    assign fetch      = buf0_q;

    // Next-state logic: flush has priority, then bus ack / FIFO push-pop bookkeeping.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        halt_d    = halt_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        push      = 1'b0;
        pop       = fetch_vld & fetch_rdy;
        new_entry = '{pc: pc_q, ir: instr_data};
        new_err   = 1'b0;
        cnt_after = cnt_q;

        if (flush) begin
            // Any ack this cycle is dropped; an unacked request must still be drained.
            cnt_d  = 2'd0;
            pc_d   = {flush_target[31:2], 2'b00};
            halt_d = 1'b0;
            if (state_q != IDLE && !instr_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = REQ;
            end
        end else begin
            cnt_after = cnt_q - {1'b0, pop};
            case (state_q)
                IDLE: begin
                    if (cnt_q < FULL && !halt_q) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (instr_ack) begin
                        push      = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        cnt_after = cnt_q + 2'd1 - {1'b0, pop};
                        if (ack_is_err) begin
                            new_entry.ir = NOP_IR;
                            new_err      = 1'b1;
                            halt_d       = 1'b1;
                            state_d      = IDLE;
                        end else if (cnt_after < FULL) begin
                            state_d = REQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (instr_ack) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Shift-style FIFO: buf0 is always the head so fetch comes straight from a register.
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        buf0_d = new_entry;
                        err0_d = new_err;
                    end else begin
                        buf1_d = new_entry;
                        err1_d = new_err;
                    end
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    err0_d = err1_q;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        buf0_d = new_entry;
                        err0_d = new_err;
                    end else begin
                        buf0_d = buf1_q;
                        err0_d = err1_q;
                        buf1_d = new_entry;
                        err1_d = new_err;
                    end
                end
                default: ;
            endcase
            cnt_d = cnt_after;
        end

        // A new request always starts at the (possibly just updated) PC; DRAIN keeps the stale address.
        if (state_d == REQ) begin
            addr_d = pc_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rstz) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, bus address, FIFO storage and halt flag.
    always_ff @(posedge clk) begin
        if (rstz) begin
            pc_q   <= BOOT_ADDR;
            addr_q <= BOOT_ADDR;
            cnt_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
            halt_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            halt_q <= halt_d;
            err0_q <= err0_d;
            err1_q <= err1_d;
        end
    end

endmodule
